// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial pattern detector with run control.
// A host loads pattern/length/overlap/limit while the engine is not running.
// A run shifts qualified serial bits into a history register, pulses on each
// match and counts matches until an optional limit moves it to DONE.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_limit,
    input  logic               start,
    input  logic               abort,
    input  logic               din_valid,
    input  logic               din,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [MAX_LEN-1:0] PAT_RST  = MAX_LEN'(4'b1010);
    localparam logic [LEN_W-1:0]   LEN_RST  = LEN_W'(4);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   lim_q, lim_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;

    logic [LEN_W-1:0]   lenClamped;
    logic [MAX_LEN-1:0] histShift;
    logic [LEN_W-1:0]   fillShift;
    logic [MAX_LEN-1:0] lenMask;
    logic               hit;
    logic [CNT_W-1:0]   cntInc;

    // Shifted history, saturating fill, length mask and match test for the incoming bit
    always_comb begin
        lenClamped = cfg_len;
        if (cfg_len == '0) begin
            lenClamped = LEN_W'(1);
        end else if (cfg_len > LEN_MAX) begin
            lenClamped = LEN_MAX;
        end
        histShift = {hist_q[MAX_LEN-2:0], din};
        fillShift = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
        lenMask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            lenMask[i] = (i < int'(len_q));
        end
        hit    = (fillShift >= len_q) && (((histShift ^ pat_q) & lenMask) == '0);
        cntInc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state logic: config capture, run start, abort, and match/limit handling
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        lim_d   = lim_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (cfg_valid) begin
                    pat_d = cfg_pattern;
                    len_d = lenClamped;
                    ovl_d = cfg_overlap;
                    lim_d = cfg_limit;
                end
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (din_valid) begin
                    hist_d = histShift;
                    fill_d = fillShift;
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cntInc;
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
                        if ((lim_q != '0) && (cntInc == lim_q)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and configuration registers, cleared to defaults immediately on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= PAT_RST;
            len_q   <= LEN_RST;
            ovl_q   <= 1'b1;
            lim_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            lim_q   <= lim_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end

    assign cfg_ready   = (state_q != RUN);
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign match       = match_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed testbench for seq_detect_ctrl with hand-computed expectations.
module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk;
    logic               reset;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_limit;
    logic               start;
    logic               abort;
    logic               din_valid;
    logic               din;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;

    int assertCount = 0;
    int failCount   = 0;

    seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
        .start(start), .abort(abort), .din_valid(din_valid), .din(din),
        .match(match), .match_count(match_count), .busy(busy), .done(done)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it and report any difference
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one qualified bit across one rising edge; returns 1ns after the edge
    task automatic applyStimulus(input logic b);
        din_valid = 1'b1;
        din       = b;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 1'b0;
    endtask

    // Idle cycle with no qualified data
    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    // Config write, optionally with start in the same cycle
    task automatic configure(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                             input logic ov, input logic [CNT_W-1:0] lim, input logic st);
        cfg_valid   = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        cfg_limit   = lim;
        start       = st;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Feed n bits (MSB of bits first); expMask gives the expected match after each bit
    task automatic runStream(input string tag, input logic [31:0] bits, input int n,
                             input logic [31:0] expMask, input bit gaps);
        for (int i = 0; i < n; i++) begin
            applyStimulus(bits[n-1-i]);
            checkOutput($sformatf("%s_match_bit%0d", tag, i + 1), {31'd0, match}, {31'd0, expMask[n-1-i]});
            if (gaps) begin
                idleCycle();
                checkOutput($sformatf("%s_idle_after%0d", tag, i + 1), {31'd0, match}, 32'd0);
            end
        end
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; cfg_limit = '0; start = 1'b0; abort = 1'b0;
        din_valid = 1'b0; din = 1'b0;
        #12;
        reset = 1'b0;
        idleCycle();

        // Reset state
        checkOutput("rst_busy",  {31'd0, busy},  32'd0);
        checkOutput("rst_done",  {31'd0, done},  32'd0);
        checkOutput("rst_match", {31'd0, match}, 32'd0);
        checkOutput("rst_count", {24'd0, match_count}, 32'd0);
        checkOutput("rst_ready", {31'd0, cfg_ready}, 32'd1);

        // 1: default config, overlapping 101010; a start mid-run must be ignored
        pulseStart();
        checkOutput("s1_busy",  {31'd0, busy}, 32'd1);
        checkOutput("s1_ready", {31'd0, cfg_ready}, 32'd0);
        runStream("s1a", 32'b1010, 4, 32'b0001, 1'b0);
        pulseStart();
        checkOutput("s1_start_ignored", {24'd0, match_count}, 32'd1);
        runStream("s1b", 32'b10, 2, 32'b01, 1'b0);
        checkOutput("s1_count", {24'd0, match_count}, 32'd2);
        checkOutput("s1_busy_end", {31'd0, busy}, 32'd1);
        checkOutput("s1_done_end", {31'd0, done}, 32'd0);
        abort = 1'b1; idleCycle(); abort = 1'b0;

        // 2: non-overlap then overlap on 10101010
        configure(8'b1010, 4'd4, 1'b0, 8'd0, 1'b0);
        pulseStart();
        runStream("s2n", 32'b10101010, 8, 32'b00010001, 1'b0);
        checkOutput("s2n_count", {24'd0, match_count}, 32'd2);
        abort = 1'b1; idleCycle(); abort = 1'b0;
        configure(8'b1010, 4'd4, 1'b1, 8'd0, 1'b0);
        pulseStart();
        runStream("s2o", 32'b10101010, 8, 32'b00010101, 1'b0);
        checkOutput("s2o_count", {24'd0, match_count}, 32'd3);
        abort = 1'b1; idleCycle(); abort = 1'b0;

        // 3: pattern 110, limit 2 ends the run on the second match
        configure(8'b110, 4'd3, 1'b1, 8'd2, 1'b0);
        pulseStart();
        runStream("s3a", 32'b110110, 6, 32'b001001, 1'b0);
        checkOutput("s3_done",  {31'd0, done}, 32'd1);
        checkOutput("s3_busy",  {31'd0, busy}, 32'd0);
        checkOutput("s3_ready", {31'd0, cfg_ready}, 32'd1);
        runStream("s3b", 32'b111, 3, 32'b000, 1'b0);
        checkOutput("s3_count_hold", {24'd0, match_count}, 32'd2);

        // 4: config and start together from DONE, idle gaps between bits
        configure(8'b1010, 4'd4, 1'b1, 8'd0, 1'b1);
        checkOutput("s4_done_clr", {31'd0, done}, 32'd0);
        checkOutput("s4_count_clr", {24'd0, match_count}, 32'd0);
        runStream("s4", 32'b101010, 6, 32'b000101, 1'b1);
        checkOutput("s4_count", {24'd0, match_count}, 32'd2);
        abort = 1'b1; idleCycle(); abort = 1'b0;

        // 5: abort discards the completing bit; restart clears history
        pulseStart();
        runStream("s5a", 32'b101, 3, 32'b000, 1'b0);
        abort = 1'b1;
        applyStimulus(1'b0);
        abort = 1'b0;
        checkOutput("s5_abort_match", {31'd0, match}, 32'd0);
        checkOutput("s5_abort_busy",  {31'd0, busy}, 32'd0);
        checkOutput("s5_abort_done",  {31'd0, done}, 32'd0);
        checkOutput("s5_abort_count", {24'd0, match_count}, 32'd0);
        pulseStart();
        runStream("s5b", 32'b01010, 5, 32'b00001, 1'b0);
        checkOutput("s5_count", {24'd0, match_count}, 32'd1);
        abort = 1'b1; idleCycle(); abort = 1'b0;

        // Length clamp above MAX_LEN: 15 behaves as 8
        configure(8'hA5, 4'd15, 1'b1, 8'd0, 1'b1);
        runStream("clhi", 32'hA5, 8, 32'h01, 1'b0);
        abort = 1'b1; idleCycle(); abort = 1'b0;

        // Length 0 clamps to 1; count saturates at 255
        configure(8'h01, 4'd0, 1'b1, 8'd0, 1'b1);
        for (int i = 0; i < 255; i++) applyStimulus(1'b1);
        checkOutput("sat_255", {24'd0, match_count}, 32'd255);
        applyStimulus(1'b1);
        checkOutput("sat_hold", {24'd0, match_count}, 32'd255);
        checkOutput("sat_match", {31'd0, match}, 32'd1);
        abort = 1'b1; idleCycle(); abort = 1'b0;

        // 6: asynchronous reset mid-run, then default config restored
        configure(8'b0110, 4'd4, 1'b0, 8'd5, 1'b1);
        runStream("s6a", 32'b0110, 4, 32'b0001, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("s6_async_busy",  {31'd0, busy}, 32'd0);
        checkOutput("s6_async_match", {31'd0, match}, 32'd0);
        checkOutput("s6_async_count", {24'd0, match_count}, 32'd0);
        #3;
        reset = 1'b0;
        idleCycle();
        pulseStart();
        runStream("s6b", 32'b101010, 6, 32'b000101, 1'b0);
        checkOutput("s6_count", {24'd0, match_count}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial pattern-detection controller. It holds a runtime-loadable pattern configuration, sequences detection runs with start/abort/done control, and counts matches against a programmable limit. It sits between the host/config logic and the serial bit stream, replacing fixed-pattern detectors with one configurable, run-controlled engine.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (must be >= 4).
CNT_W, 8, width of the match counter and limit.
LEN_W, $clog2(MAX_LEN+1), width of the length field (derived).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
cfg_valid  input  1  config write request.
cfg_ready  output  1  config accepted this cycle when cfg_valid && cfg_ready.
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit received.
cfg_len  input  LEN_W  pattern length.
cfg_overlap  input  1  1 = overlapping matches allowed.
cfg_limit  input  CNT_W  match count that ends the run; 0 = unlimited.
start  input  1  begin a run.
abort  input  1  cancel a run.
din_valid  input  1  din qualifier.
din  input  1  serial input bit.
match  output  1  one-cycle pulse per detected match.
match_count  output  CNT_W  matches in the current/last run.
busy  output  1  high in RUN.
done  output  1  high in DONE.

Behaviour:
- States: IDLE, RUN, DONE. Reset: IDLE, match=0, match_count=0, busy=0, done=0, history and fill cleared. Config resets to pattern=1010 (zero-extended), len=4, overlap=1, limit=0. Reset acts immediately, not at the next edge.
- cfg_ready=1 in IDLE and DONE, 0 in RUN. On accept, latch all cfg_* fields. cfg_len=0 clamps to 1; cfg_len>MAX_LEN clamps to MAX_LEN.
- If cfg_valid and start occur in the same cycle, the config is latched first and the run uses the new config.
- start in IDLE/DONE: next state RUN. Clears match_count, history, fill and done. start in RUN is ignored.
- In RUN, on each edge with din_valid=1: hist <= {hist[MAX_LEN-2:0], din}; fill <= min(fill+1, MAX_LEN). Edges with din_valid=0 change nothing.
- Match condition, evaluated on the updated values: fill_next >= len and hist_next[len-1:0] == pattern[len-1:0].
- On a match, at the same edge: match<=1 for exactly one cycle (visible the cycle after the final bit is sampled). match_count increments and saturates at 2^CNT_W-1 with no wrap.
- Non-overlap mode: fill resets to 0 on a match, so matched bits are not reused. Overlap mode: fill is retained.
- Limit: if limit!=0 and the incremented count == limit, next state is DONE (busy=0, done=1) at the same edge as the final match pulse. In DONE, din is ignored and match_count holds.
- abort in RUN: next state IDLE. match_count is retained, done stays 0, and the bit sampled that cycle is discarded (no match). abort wins over a simultaneous match. abort in IDLE/DONE is ignored.
- match is 0 in every cycle that has no match edge. busy and done are registered state decodes.

Test Plan:
1. Reset, start, din=1,0,1,0,1,0 contiguous with valid=1 (default config, overlap) -> match pulses after bits 4 and 6; match_count=2; busy=1, done=0.
2. Config pattern=1010, len=4, overlap=0, limit=0; start; din=10101010 -> matches after bits 4 and 8 only; count=2. Same stream with overlap=1 -> count=3.
3. Config pattern=110, len=3, limit=2; start; din=110110111 -> pulses after bits 3 and 6; done=1, busy=0, cfg_ready=1 at that edge; later bits produce no pulse; count holds at 2.
4. Scenario 1 stream with din_valid=0 idle cycles interleaved -> identical match sequence and count; no pulse on any idle cycle.
5. Default config; start; din=1,0,1; abort together with the 4th bit 0 -> IDLE, no match, count=0. Restart and drive din=0 -> no match (history cleared). Then 1,0,1,0 -> one match.
6. Assert reset asynchronously mid-RUN between clock edges -> busy, match and match_count go 0 immediately. After release, config reads as the default (1010/4/overlap/unlimited) and a start plus 1010 gives one match.
